// File: rtl/packet_struct_pkg.sv
// Shared packet definitions: IPv4 header layout and packet timestamp width.
package packet_struct_pkg;

    localparam int unsigned IP_HDR_BYTES    = 20;
    localparam int unsigned IP_HDR_W        = IP_HDR_BYTES * 8;
    localparam int unsigned PKT_TIMESTAMP_W = 64;

    // Field order matches wire order, so the first header byte lands in the MSBs.
    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] tot_len;
        logic [15:0] id;
        logic [2:0]  flags;
        logic [12:0] frag_off;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] checksum;
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
    } ip_pkt_hdr;

endpackage

// File: rtl/ip_tx_hdr_prepend.sv
// Prepends a 20-byte IP header to a payload stream, realigning payload bytes
// across beats and emitting a trailing drain beat when the carry overflows.
module ip_tx_hdr_prepend
    import packet_struct_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 256,
    localparam int unsigned BYTES      = DATA_WIDTH / 8,
    localparam int unsigned PAD_W      = $clog2(BYTES),
    localparam int unsigned HDR_BYTES  = IP_HDR_BYTES
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       hdr_val,
    output logic                       hdr_rdy,
    input  ip_pkt_hdr                  hdr,
    input  logic [PKT_TIMESTAMP_W-1:0] hdr_timestamp,

    input  logic                       payload_val,
    output logic                       payload_rdy,
    input  logic [DATA_WIDTH-1:0]      payload_data,
    input  logic                       payload_last,
    input  logic [PAD_W-1:0]           payload_padbytes,

    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic [PAD_W-1:0]           out_padbytes,
    output logic [PKT_TIMESTAMP_W-1:0] out_timestamp
);

    localparam int unsigned   REMAIN_W = DATA_WIDTH - IP_HDR_W;
    localparam logic [PAD_W-1:0] HDR_PAD  = PAD_W'(HDR_BYTES);
    localparam logic [PAD_W-1:0] TAIL_PAD = PAD_W'(BYTES - HDR_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        HDR_ONLY,
        FIRST,
        BODY,
        DRAIN
    } state_t;

    state_t                       state;
    ip_pkt_hdr                    hdr_reg;
    logic [IP_HDR_W-1:0]          carry_reg;
    logic [PAD_W-1:0]             pad_reg;
    logic [PKT_TIMESTAMP_W-1:0]   ts_reg;

    logic [IP_HDR_W-1:0]          hdr_bits;
    logic [IP_HDR_W-1:0]          lead;
    logic                         beat_fire;
    logic                         tail_fits;

    assign hdr_bits      = hdr_reg;
    assign out_timestamp = ts_reg;
    assign beat_fire     = payload_val && out_rdy;
    // The last payload beat's tail fits in the current output beat only if its
    // padding can absorb the header bytes shifted in ahead of it.
    assign tail_fits     = payload_padbytes >= HDR_PAD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hdr_reg   <= '0;
            carry_reg <= '0;
            pad_reg   <= '0;
            ts_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_val) begin
                        hdr_reg <= hdr;
                        ts_reg  <= hdr_timestamp;
                        state   <= (hdr.tot_len == 16'(HDR_BYTES)) ? HDR_ONLY : FIRST;
                    end
                end
                HDR_ONLY, DRAIN: begin
                    if (out_rdy) begin
                        state <= IDLE;
                    end
                end
                FIRST, BODY: begin
                    if (beat_fire) begin
                        carry_reg <= payload_data[IP_HDR_W-1:0];
                        if (!payload_last) begin
                            state <= BODY;
                        end else if (tail_fits) begin
                            state <= IDLE;
                        end else begin
                            pad_reg <= payload_padbytes;
                            state   <= DRAIN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        hdr_rdy      = 1'b0;
        payload_rdy  = 1'b0;
        out_val      = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        out_padbytes = '0;
        lead         = (state == FIRST) ? hdr_bits : carry_reg;
        // Handshakes are forced low while reset is held, even though state already reads IDLE.
        if (rst) begin
            case (state)
                IDLE: begin
                    hdr_rdy = 1'b1;
                end
                HDR_ONLY: begin
                    out_val      = 1'b1;
                    out_data     = {hdr_bits, {REMAIN_W{1'b0}}};
                    out_last     = 1'b1;
                    out_padbytes = TAIL_PAD;
                end
                FIRST, BODY: begin
                    payload_rdy = out_rdy;
                    out_val     = payload_val;
                    if (payload_val) begin
                        out_data = {lead, payload_data[DATA_WIDTH-1 -: REMAIN_W]};
                        if (payload_last && tail_fits) begin
                            out_last     = 1'b1;
                            out_padbytes = payload_padbytes - HDR_PAD;
                        end
                    end
                end
                DRAIN: begin
                    out_val      = 1'b1;
                    out_data     = {carry_reg, {REMAIN_W{1'b0}}};
                    out_last     = 1'b1;
                    out_padbytes = TAIL_PAD + pad_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tx_hdr_prepend.sv
// Directed bench for ip_tx_hdr_prepend: fixed payload/header vectors with
// hand-derived output beats, stalls, mid-packet reset and back-to-back packets.
module tb_ip_tx_hdr_prepend;
    import packet_struct_pkg::*;

    localparam int unsigned DW = 256;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic [4:0]    pad;
        bit            cons;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          hdr_val;
    logic          hdr_rdy;
    ip_pkt_hdr     hdr;
    logic [63:0]   hdr_timestamp;
    logic          payload_val;
    logic          payload_rdy;
    logic [DW-1:0] payload_data;
    logic          payload_last;
    logic [4:0]    payload_padbytes;
    logic          out_val;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [4:0]    out_padbytes;
    logic [63:0]   out_timestamp;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    beat_t pay_q[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    ip_tx_hdr_prepend #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .hdr_val          (hdr_val),
        .hdr_rdy          (hdr_rdy),
        .hdr              (hdr),
        .hdr_timestamp    (hdr_timestamp),
        .payload_val      (payload_val),
        .payload_rdy      (payload_rdy),
        .payload_data     (payload_data),
        .payload_last     (payload_last),
        .payload_padbytes (payload_padbytes),
        .out_val          (out_val),
        .out_rdy          (out_rdy),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_padbytes     (out_padbytes),
        .out_timestamp    (out_timestamp)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [159:0] mk_hdr(input logic [15:0] tot_len, input logic [7:0] id);
        ip_pkt_hdr h;
        h          = '0;
        h.version  = 4'd4;
        h.ihl      = 4'd5;
        h.tot_len  = tot_len;
        h.id       = {8'hA0, id};
        h.ttl      = 8'd64;
        h.protocol = 8'd17;
        h.checksum = 16'hBEEF ^ {id, id};
        h.src_addr = 32'h0A00_0001;
        h.dst_addr = 32'h0A00_00FE;
        return h;
    endfunction

    // First byte in the MSBs; unused trailing bytes are zero.
    function automatic logic [DW-1:0] mk_pay(input int nbytes, input logic [7:0] base);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbytes) v[DW-1-8*i -: 8] = 8'(base + i);
        end
        return v;
    endfunction

    task automatic add_pay(input logic [DW-1:0] d, input logic last, input logic [4:0] pad);
        beat_t b;
        b.d = d; b.last = last; b.pad = pad; b.cons = 1'b1;
        pay_q.push_back(b);
    endtask

    task automatic add_exp(input logic [DW-1:0] d, input logic last, input logic [4:0] pad,
                           input bit cons);
        beat_t b;
        b.d = d; b.last = last; b.pad = pad; b.cons = cons;
        exp_q.push_back(b);
    endtask

    // pre: header already on the bus and hdr_rdy seen high at the preceding negedge.
    // hold_next: keep the next header asserted on the bus while this packet streams.
    task automatic run_pkt(input string name, input logic [159:0] h, input logic [63:0] ts,
                           input bit toggle, input bit pre, input bit hold_next,
                           input logic [159:0] nh, input logic [63:0] nts);
        int  guard;
        int  pi;
        bit  phase;
        bit  done;
        if (!pre) begin
            @(negedge clk);
            hdr = h; hdr_timestamp = ts; hdr_val = 1'b1;
            #1;
            guard = 0;
            while (!hdr_rdy && guard < 20) begin
                @(negedge clk); #1; guard++;
            end
            check({name, "_hdr_rdy"}, hdr_rdy, 1);
        end
        @(posedge clk); #1;
        if (hold_next) begin
            hdr = nh; hdr_timestamp = nts;
        end else begin
            hdr_val = 1'b0;
        end
        phase = 1'b0;
        pi    = 0;
        foreach (exp_q[k]) begin
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (exp_q[k].cons) begin
                    payload_val      = 1'b1;
                    payload_data     = pay_q[pi].d;
                    payload_last     = pay_q[pi].last;
                    payload_padbytes = pay_q[pi].pad;
                end else begin
                    payload_val      = 1'b0;
                    payload_data     = '0;
                    payload_last     = 1'b0;
                    payload_padbytes = '0;
                end
                out_rdy = toggle ? phase : 1'b1;
                phase   = ~phase;
                #1;
                check($sformatf("%s_b%0d_val", name, k), out_val, 1);
                check($sformatf("%s_b%0d_data", name, k), out_data, exp_q[k].d);
                check($sformatf("%s_b%0d_last", name, k), out_last, exp_q[k].last);
                check($sformatf("%s_b%0d_pad", name, k), out_padbytes, exp_q[k].pad);
                check($sformatf("%s_b%0d_ts", name, k), out_timestamp, ts);
                check($sformatf("%s_b%0d_hdr_rdy", name, k), hdr_rdy, 0);
                check($sformatf("%s_b%0d_pay_rdy", name, k), payload_rdy,
                      exp_q[k].cons ? out_rdy : 1'b0);
                @(posedge clk);
                if (out_rdy) begin
                    done = 1'b1;
                    if (exp_q[k].cons) pi++;
                end
            end
        end
        @(negedge clk);
        payload_val = 1'b0; payload_last = 1'b0; payload_padbytes = '0; out_rdy = 1'b1;
        #1;
        check({name, "_end_val"}, out_val, 0);
        check({name, "_end_hdr_rdy"}, hdr_rdy, 1);
        pay_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [159:0]  h1, h2;
        logic [DW-1:0] pa, pb;

        rst = 1'b0; hdr_val = 1'b0; hdr = '0; hdr_timestamp = '0;
        payload_val = 1'b0; payload_data = '0; payload_last = 1'b0; payload_padbytes = '0;
        out_rdy = 1'b1;
        #2;
        check("rst_hdr_rdy", hdr_rdy, 0);
        check("rst_out_val", out_val, 0);
        check("rst_pay_rdy", payload_rdy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_hdr_rdy", hdr_rdy, 1);
        check("post_rst_out_val", out_val, 0);
        check("post_rst_out_data", out_data, 0);
        check("post_rst_out_last", out_last, 0);
        check("post_rst_out_pad", out_padbytes, 0);

        // Header-only packet
        h1 = mk_hdr(16'd20, 8'h01);
        add_exp({h1, 96'b0}, 1'b1, 5'd12, 1'b0);
        run_pkt("hdronly", h1, 64'h5, 1'b0, 1'b0, 1'b0, '0, '0);

        // 10-byte payload, single output beat
        h1 = mk_hdr(16'd30, 8'h02);
        pa = mk_pay(10, 8'h10);
        add_pay(pa, 1'b1, 5'd22);
        add_exp({h1, pa[255:160]}, 1'b1, 5'd2, 1'b1);
        run_pkt("p10", h1, 64'h6, 1'b0, 1'b0, 1'b0, '0, '0);

        // 32-byte payload: spills 20 bytes into a drain beat
        h1 = mk_hdr(16'd52, 8'h03);
        pa = mk_pay(32, 8'h40);
        add_pay(pa, 1'b1, 5'd0);
        add_exp({h1, pa[255:160]}, 1'b0, 5'd0, 1'b1);
        add_exp({pa[159:0], 96'b0}, 1'b1, 5'd12, 1'b0);
        run_pkt("p32", h1, 64'h7, 1'b0, 1'b0, 1'b0, '0, '0);

        // 64-byte payload with downstream stalling every other cycle
        h1 = mk_hdr(16'd84, 8'h04);
        pa = mk_pay(32, 8'h80);
        pb = mk_pay(32, 8'hA0);
        add_pay(pa, 1'b0, 5'd0);
        add_pay(pb, 1'b1, 5'd0);
        add_exp({h1, pa[255:160]}, 1'b0, 5'd0, 1'b1);
        add_exp({pa[159:0], pb[255:160]}, 1'b0, 5'd0, 1'b1);
        add_exp({pb[159:0], 96'b0}, 1'b1, 5'd12, 1'b0);
        run_pkt("p64", h1, 64'h8, 1'b1, 1'b0, 1'b0, '0, '0);

        // Padding exactly equal to the header size: no drain beat
        h1 = mk_hdr(16'd32, 8'h05);
        pa = mk_pay(12, 8'h30);
        add_pay(pa, 1'b1, 5'd20);
        add_exp({h1, pa[255:160]}, 1'b1, 5'd0, 1'b1);
        run_pkt("pad20", h1, 64'h9, 1'b0, 1'b0, 1'b0, '0, '0);

        // Padding one below the header size: drain beat with 31 pad bytes
        h1 = mk_hdr(16'd33, 8'h06);
        pa = mk_pay(13, 8'h50);
        add_pay(pa, 1'b1, 5'd19);
        add_exp({h1, pa[255:160]}, 1'b0, 5'd0, 1'b1);
        add_exp({pa[159:0], 96'b0}, 1'b1, 5'd31, 1'b0);
        run_pkt("pad19", h1, 64'hA, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of BODY
        h1 = mk_hdr(16'd84, 8'h07);
        pa = mk_pay(32, 8'h60);
        pb = mk_pay(32, 8'h70);
        @(negedge clk);
        hdr = h1; hdr_timestamp = 64'hB; hdr_val = 1'b1;
        #1;
        check("mrst_hdr_rdy", hdr_rdy, 1);
        @(posedge clk); #1;
        hdr_val = 1'b0;
        @(negedge clk);
        payload_val = 1'b1; payload_data = pa; payload_last = 1'b0; payload_padbytes = '0;
        out_rdy = 1'b1;
        #1;
        check("mrst_first_data", out_data, {h1, pa[255:160]});
        @(negedge clk);
        payload_data = pb; payload_last = 1'b1;
        #1;
        check("mrst_body_val", out_val, 1);
        check("mrst_body_data", out_data, {pa[159:0], pb[255:160]});
        rst = 1'b0;
        #1;
        check("mrst_out_val", out_val, 0);
        check("mrst_pay_rdy", payload_rdy, 0);
        check("mrst_hdr_rdy_low", hdr_rdy, 0);
        @(negedge clk);
        rst = 1'b1;
        payload_val = 1'b0; payload_last = 1'b0; payload_data = '0;
        #1;
        check("mrst_rel_hdr_rdy", hdr_rdy, 1);
        check("mrst_rel_out_val", out_val, 0);
        check("mrst_rel_out_data", out_data, 0);
        check("mrst_rel_ts", out_timestamp, 0);

        h1 = mk_hdr(16'd30, 8'h08);
        pa = mk_pay(10, 8'h20);
        add_pay(pa, 1'b1, 5'd22);
        add_exp({h1, pa[255:160]}, 1'b1, 5'd2, 1'b1);
        run_pkt("after_rst", h1, 64'hC, 1'b0, 1'b0, 1'b0, '0, '0);

        // Back-to-back: second header held on the bus throughout the first packet
        h1 = mk_hdr(16'd60, 8'h09);
        h2 = mk_hdr(16'd20, 8'h0A);
        pa = mk_pay(32, 8'h01);
        pb = mk_pay(8, 8'hC0);
        add_pay(pa, 1'b0, 5'd0);
        add_pay(pb, 1'b1, 5'd24);
        add_exp({h1, pa[255:160]}, 1'b0, 5'd0, 1'b1);
        add_exp({pa[159:0], pb[255:160]}, 1'b1, 5'd4, 1'b1);
        run_pkt("b2b_1", h1, 64'h11, 1'b0, 1'b0, 1'b1, h2, 64'h22);
        add_exp({h2, 96'b0}, 1'b1, 5'd12, 1'b0);
        run_pkt("b2b_2", h2, 64'h22, 1'b0, 1'b1, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
